// File: rtl/wb_pkg.sv
// Shared widths, queue entry type and the youngest-pending-write search
// used by writeback_queue and wb_fifo.
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  // Must be a power of two and at least 2 so the pointers wrap naturally.
  localparam int DEPTH  = 4;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] da;
    logic [DATA_W-1:0] d;
  } wb_entry_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } wb_match_t;

  // Walk from oldest to youngest so the last match seen is the youngest.
  function automatic wb_match_t youngest_match(
    input wb_entry_t [DEPTH-1:0] entries,
    input logic      [DEPTH-1:0] valid_mask,
    input logic      [PTR_W-1:0] rd_ptr,
    input logic      [ADDR_W-1:0] addr
  );
    wb_match_t        m;
    logic [PTR_W-1:0] idx;
    m   = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (valid_mask[idx] && (entries[idx].da == addr)) begin
        m.hit  = 1'b1;
        m.data = entries[idx].d;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Producer-side bundle: memory-load and ALU result channels.
interface writeback_queue_if;
  import wb_pkg::*;

  // valid/ready: an entry transfers on a rising edge where valid && ready.
  // A producer holds da/d stable while valid is high and ready is low;
  // ready never depends on alu_valid, and mem has priority for free slots.
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_da;
  logic [DATA_W-1:0] mem_d;
  logic              mem_ready;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_da;
  logic [DATA_W-1:0] alu_d;
  logic              alu_ready;

  modport master (
    output mem_valid, mem_da, mem_d, alu_valid, alu_da, alu_d,
    input  mem_ready, alu_ready
  );

  modport slave (
    input  mem_valid, mem_da, mem_d, alu_valid, alu_da, alu_d,
    output mem_ready, alu_ready
  );

endinterface

// File: rtl/wb_fifo.sv
// Dual-push / single-pop circular buffer. push_a is always the older of
// two same-cycle entries; overflow is prevented by the caller's ready gating.
module wb_fifo
  import wb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_a,
  input  wb_entry_t              entry_a,
  input  logic                   push_b,
  input  wb_entry_t              entry_b,
  input  logic                   pop,
  output wb_entry_t              head,
  output wb_entry_t [DEPTH-1:0]  slots,
  output logic      [DEPTH-1:0]  valid_mask,
  output logic      [PTR_W-1:0]  rd_ptr,
  output logic      [CNT_W-1:0]  count
);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      wr_ptr_b;
  logic [CNT_W-1:0]      n_push;
  logic [PTR_W-1:0]      off;

  assign n_push   = CNT_W'(push_a) + CNT_W'(push_b);
  assign wr_ptr_b = push_a ? (wr_ptr + PTR_W'(1)) : wr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_push[PTR_W-1:0];
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + n_push - CNT_W'(pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push_a) mem_q[wr_ptr]   <= entry_a;
      if (push_b) mem_q[wr_ptr_b] <= entry_b;
    end
  end

  always_comb begin
    valid_mask = '0;
    off        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off           = PTR_W'(i) - rd_ptr;
      valid_mask[i] = ({1'b0, off} < count);
    end
  end

  assign head  = mem_q[rd_ptr];
  assign slots = mem_q;

endmodule

// File: rtl/writeback_queue.sv
// Write-side front end of the 16x16 register file: arbitrates ALU and load
// results into an in-order queue and retires one write per cycle.
// Optional pending-write forwarding: define WRITEBACK_QUEUE_BYPASS_EN.
module writeback_queue
  import wb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  writeback_queue_if.slave    prod,
  input  logic                hold,
  output logic [DATA_W-1:0]   D,
  output logic [ADDR_W-1:0]   DA,
  output logic                RW,
  input  logic [ADDR_W-1:0]   AA,
  input  logic [ADDR_W-1:0]   BA,
  output logic                a_hit,
  output logic [DATA_W-1:0]   a_fwd,
  output logic                b_hit,
  output logic [DATA_W-1:0]   b_fwd,
  output logic [ADDR_W:0]     count,
  output logic                empty,
  output logic                full
);

  localparam int COUNT_W = ADDR_W + 1;

  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] slots;
  logic [DEPTH-1:0]      valid_mask;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      occ;
  logic [CNT_W-1:0]      free;
  logic                  mem_hs;
  logic                  alu_hs;
  logic                  push_a;
  logic                  push_b;
  wb_entry_t             entry_a;
  wb_entry_t             entry_b;

  // Free space uses registered occupancy only; a same-cycle pop is not credited.
  assign free           = CNT_W'(DEPTH) - occ;
  assign prod.mem_ready = (free != '0);
  assign prod.alu_ready = prod.mem_valid ? (free >= CNT_W'(2)) : (free != '0);

  assign mem_hs  = prod.mem_valid & prod.mem_ready;
  assign alu_hs  = prod.alu_valid & prod.alu_ready;
  assign push_a  = mem_hs | alu_hs;
  assign push_b  = mem_hs & alu_hs;
  assign entry_a = mem_hs ? wb_entry_t'{da: prod.mem_da, d: prod.mem_d}
                          : wb_entry_t'{da: prod.alu_da, d: prod.alu_d};
  assign entry_b = wb_entry_t'{da: prod.alu_da, d: prod.alu_d};

  wb_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_a     (push_a),
    .entry_a    (entry_a),
    .push_b     (push_b),
    .entry_b    (entry_b),
    .pop        (RW),
    .head       (head),
    .slots      (slots),
    .valid_mask (valid_mask),
    .rd_ptr     (rd_ptr),
    .count      (occ)
  );

  assign empty = (occ == '0);
  assign full  = (occ == CNT_W'(DEPTH));
  assign count = COUNT_W'(occ);

  // The register file always accepts, so asserting RW pops the head this edge.
  assign RW = !empty && !hold && !reset;
  assign D  = empty ? '0 : head.d;
  assign DA = empty ? '0 : head.da;

`ifdef WRITEBACK_QUEUE_BYPASS_EN
  wb_match_t match_a;
  wb_match_t match_b;

  assign match_a = youngest_match(slots, valid_mask, rd_ptr, AA);
  assign match_b = youngest_match(slots, valid_mask, rd_ptr, BA);
  assign a_hit   = match_a.hit;
  assign a_fwd   = match_a.data;
  assign b_hit   = match_b.hit;
  assign b_fwd   = match_b.data;
`else
  logic unused_bypass;

  assign a_hit         = 1'b0;
  assign a_fwd         = '0;
  assign b_hit         = 1'b0;
  assign b_fwd         = '0;
  assign unused_bypass = ^{AA, BA, slots, valid_mask, rd_ptr};
`endif

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Write-side front end for the 16x16 register file. Owns the file's write port (D, DA, RW).
- Accepts results from two producers, ALU and memory-load, over valid/ready.
- Buffers results in an in-order queue and retires at most one write per cycle.
- Optionally forwards pending (not yet written) data to the operand-read side so readers never see stale values.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register address width (2^ADDR_W registers)
- DEPTH, 4, queue entries; power of two, >=2

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  memory-load result offered
- mem_da  in  ADDR_W  destination register of load
- mem_d  in  DATA_W  load data
- mem_ready  out  1  queue accepts mem entry this cycle
- alu_valid  in  1  ALU result offered
- alu_da  in  ADDR_W  destination register of ALU result
- alu_d  in  DATA_W  ALU data
- alu_ready  out  1  queue accepts ALU entry this cycle
- hold  in  1  suppress retirement (freeze/debug)
- D  out  DATA_W  register-file write data
- DA  out  ADDR_W  register-file write address
- RW  out  1  register-file write enable
- AA  in  ADDR_W  operand-A read address (forwarding lookup)
- BA  in  ADDR_W  operand-B read address (forwarding lookup)
- a_hit  out  1  pending write to AA exists
- a_fwd  out  DATA_W  youngest pending data for AA
- b_hit  out  1  pending write to BA exists
- b_fwd  out  DATA_W  youngest pending data for BA
- count  out  ADDR_W+1  occupied entries
- empty  out  1  count==0
- full  out  1  count==DEPTH

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset is synchronous and active-high, sampled on the rising clk edge.
  - On reset: wr/rd pointers=0, count=0, RW=0, D=0, DA=0, all hits 0, fwd outputs 0.
  - Reset mid-operation discards all pending entries; no write issues on the reset cycle or the cycle after.
- Free space: free = DEPTH - count, using registered count. A same-cycle pop is NOT credited.
- Ready logic:
  - mem_ready = (free>=1).
  - alu_ready = mem_valid ? (free>=2) : (free>=1).
  - Ready does not depend on alu_valid. mem has priority.
- Enqueue:
  - Each handshake (valid&ready) writes one entry {da,d} at the rising edge.
  - If both handshake in the same cycle: mem entry goes in first (older), ALU entry second.
  - Up to 2 enqueues per cycle.
- Retire (combinational from head):
  - RW = !empty & !hold & !reset; DA/D = head entry.
  - When RW=1 the head pops at that edge, because the register file always accepts.
- Latency: an entry enqueued at edge N is head-visible in cycle N+1 if the queue was empty, and is written to the file at edge N+1.
- Count update: count_next = count + enq_count - pop. Simultaneous 2 enq + 1 pop when full-1 cannot occur, because ready gating prevents overflow.
- Pointers wrap modulo DEPTH.
- Ordering:
  - Strict FIFO; writes to the same DA retire in enqueue order, and the last one wins in the file.
  - No coalescing. Register 0 is an ordinary register.
- hold:
  - Freezes retirement only; enqueue continues until full.
  - Deasserting hold resumes retirement in the same cycle.
- empty/full/count reflect the registered state.

Optional Feature:
- Macro: WRITEBACK_QUEUE_BYPASS_EN.
- Defined:
  - a_hit=1 iff any occupied entry has da==AA; a_fwd = data of the youngest such entry. Same rule for BA/b_*.
  - The search covers the head entry, including one retiring this cycle.
  - Entries enqueued in the current cycle are not visible until the next cycle.
- Undefined: a_hit=b_hit=0, a_fwd=b_fwd=0, and no compare logic is synthesized.

Decomposition:
- Package wb_pkg:
  - DATA_W, ADDR_W constants.
  - wb_entry_t typedef {da, d}.
  - Function youngest_match(entries, valid_mask, rd_ptr, addr) returning {hit, data}.
- Sub-module wb_fifo: dual-push/single-pop storage with pointers and count; the top level adds ready arbitration and the bypass lookup.

Test Plan:
- Reset, then a single ALU push (da=3, d=16'h1234) on an idle queue -> the next cycle shows RW=1, DA=3, D=16'h1234; count returns to 0 after that edge.
- mem (da=5, d=16'hAAAA) and ALU (da=5, d=16'hBBBB) in the same cycle, free>=2 -> RW pulses in two consecutive cycles: first 16'hAAAA, then 16'hBBBB; the file ends with reg5=16'hBBBB.
- hold=1 with 5 pushes offered, DEPTH=4 -> count reaches 4, full=1, mem_ready=alu_ready=0, RW=0. Releasing hold gives 4 consecutive writes in order.
- count=3, both valid -> mem_ready=1, alu_ready=0; only the mem entry is accepted and count becomes 4, or 3 if a pop occurs that cycle.
- BYPASS_EN with hold=1, entries da=7 (16'h0001) then da=7 (16'h0002), AA=7, BA=8 -> a_hit=1, a_fwd=16'h0002, b_hit=0.
- Reset asserted while 3 entries are pending -> RW=0 the next cycle; count=0, empty=1; no stale writes after reset drops.
